dmem_arbiter: RTL and testbench

- Shares the single data memory (data_mem: combinational read, synchronous byte-strobed write) between two masters.
- Port 0 is the CPU data port.
- Port 1 is a DMA/debug-loader port; it may lock the memory for bursts.
- The block sits between the masters and data_mem. Arbitration is per-cycle with a registered fairness pointer, a bounded burst lock, and a saturating contention counter for debug.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/dmem_arbiter_mux.sv | 37 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : arbiter FSM encoding (ARB / LOCK / YIELD)
//   P_CPU/P_LDR : indices of the CPU and loader ports in grant vectors
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK  = 2'd1,
        YIELD = 2'd2
    } arb_state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant bundle for one data-memory master.
//   req, we, strobe, addr, wdata : master -> arbiter request fields
//   gnt, rdata                   : arbiter -> master response
// Handshake: the master raises req with its fields and holds all of them
// stable until it samples gnt=1; the access is performed in that gnt cycle
// (rdata valid then, a write commits at the following clock edge).
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   strobe;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, strobe, addr, wdata, input gnt, rdata);
    modport slave  (input req, we, strobe, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/dmem_arbiter_mux.sv
// Steers the granted port's request fields onto the data-memory bus.
//   gnt_i          : one-hot (or zero) grant vector, indexed by P_CPU/P_LDR
//   m0_*_i, m1_*_i : request fields of CPU and loader
//   mem_*_o        : data-memory request bus
// With no grant the bus is idle (we=0, strobe=0) while addr/wdata follow
// port 0 so the bus never floats to an arbitrary value.
module dmem_arb_mux
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [1:0]          gnt_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_strobe_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_strobe_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_strobe_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o
);
    logic sel_ldr;
    logic sel_cpu;

    assign sel_ldr = gnt_i[P_LDR];
    assign sel_cpu = gnt_i[P_CPU];

    assign mem_we_o     = sel_ldr ? m1_we_i     : (sel_cpu & m0_we_i);
    assign mem_strobe_o = sel_ldr ? m1_strobe_i : (sel_cpu ? m0_strobe_i : '0);
    assign mem_addr_o   = sel_ldr ? m1_addr_i   : m0_addr_i;
    assign mem_wdata_o  = sel_ldr ? m1_wdata_i  : m0_wdata_i;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single data memory.
//   clock, rst_n    : clock, asynchronous active-low reset
//   m0 (slave)      : CPU data port
//   m1 (slave)      : DMA/debug-loader port, m1_lock keeps ownership
//   mem_*           : data-memory bus (combinational read, sync write)
//   locked          : high while the loader holds a burst lock
//   conflict_cnt    : saturating count of cycles with a refused requester
//   dbg_state_o     : current FSM state
//   dbg_lock_cnt_o  : locked grants taken in the current burst
// Grants are combinational from registered state and the current requests,
// so an uncontended access sees no extra latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         rst_n,
    dmem_req_if.slave                    m0,
    dmem_req_if.slave                    m1,
    input  logic                         m1_lock,
    output logic                         mem_we,
    output logic [DATA_W/8-1:0]          mem_strobe,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         locked,
    output logic [CNT_W-1:0]             conflict_cnt,
    output arb_state_e                   dbg_state_o,
    output logic [$clog2(MAX_LOCK)-1:0]  dbg_lock_cnt_o
);
    localparam int                LOCK_W    = $clog2(MAX_LOCK);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

    arb_state_e        st_q, st_d;
    logic              last_gnt_q, last_gnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic [1:0]        gnt_raw;
    logic [1:0]        gnt;
    logic              conflict;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ARB;
            last_gnt_q <= P_LDR;   // CPU wins the first conflict
            lock_cnt_q <= '0;
            conflict_q <= '0;
        end else begin
            st_q       <= st_d;
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = lock_cnt_q;
        gnt_raw    = '0;
        case (st_q)
            ARB: begin
                if (m0.req && (!m1.req || last_gnt_q == P_LDR)) begin
                    gnt_raw[P_CPU] = 1'b1;
                end else if (m1.req) begin
                    gnt_raw[P_LDR] = 1'b1;
                end
                if (gnt_raw[P_LDR] && m1_lock) begin
                    st_d       = LOCK;
                    lock_cnt_d = LOCK_W'(1);
                end
            end
            LOCK: begin
                if (m1.req) begin
                    gnt_raw[P_LDR] = 1'b1;
                    // The burst cap wins over a voluntary release so a
                    // waiting CPU always gets its forced slot.
                    if (lock_cnt_q == LOCK_LAST) begin
                        lock_cnt_d = '0;
                        st_d       = m0.req ? YIELD : ARB;
                    end else if (!m1_lock) begin
                        lock_cnt_d = '0;
                        st_d       = ARB;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end else begin
                    // Loader walked away: lock ends, CPU may use this cycle.
                    gnt_raw[P_CPU] = m0.req;
                    lock_cnt_d     = '0;
                    st_d           = ARB;
                end
            end
            YIELD: begin
                gnt_raw[P_CPU] = m0.req;
                last_gnt_d     = P_CPU;
                st_d           = ARB;
            end
            default: begin
                st_d       = ARB;
                lock_cnt_d = '0;
            end
        endcase
        if (gnt_raw[P_CPU]) begin
            last_gnt_d = P_CPU;
        end else if (gnt_raw[P_LDR]) begin
            last_gnt_d = P_LDR;
        end
    end

    // Grants are killed combinationally while reset is asserted so nothing
    // reaches memory even before the first clock edge of reset.
    assign gnt = gnt_raw & {2{rst_n}};

    assign conflict   = (m0.req & ~gnt[P_CPU]) | (m1.req & ~gnt[P_LDR]);
    assign conflict_d = (conflict && (conflict_q != '1)) ? conflict_q + CNT_W'(1) : conflict_q;

    dmem_arb_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .gnt_i       (gnt),
        .m0_we_i     (m0.we),
        .m0_strobe_i (m0.strobe),
        .m0_addr_i   (m0.addr),
        .m0_wdata_i  (m0.wdata),
        .m1_we_i     (m1.we),
        .m1_strobe_i (m1.strobe),
        .m1_addr_i   (m1.addr),
        .m1_wdata_i  (m1.wdata),
        .mem_we_o    (mem_we),
        .mem_strobe_o(mem_strobe),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

    assign m0.gnt         = gnt[P_CPU];
    assign m1.gnt         = gnt[P_LDR];
    assign m0.rdata       = mem_rdata;
    assign m1.rdata       = mem_rdata;
    assign locked         = (st_q == LOCK);
    assign conflict_cnt   = conflict_q;
    assign dbg_state_o    = st_q;
    assign dbg_lock_cnt_o = lock_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small byte-strobed memory model hangs off the
// mem_* bus; a reference model predicts grants, read data and status, and a
// negedge monitor checks the DUT against the queued expectations.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int ML = 4;
  localparam int CW = 16;
  localparam int LW = $clog2(ML);

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic m1_lock;
  logic mem_we;
  logic [SW-1:0] mem_strobe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic locked;
  logic [CW-1:0] conflict_cnt;
  arb_state_e dbg_state;
  logic [LW-1:0] dbg_lock_cnt;

  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML), .CNT_W(CW)) dut (
    .clock(clock), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .m1_lock(m1_lock),
    .mem_we(mem_we), .mem_strobe(mem_strobe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .locked(locked),
    .conflict_cnt(conflict_cnt), .dbg_state_o(dbg_state), .dbg_lock_cnt_o(dbg_lock_cnt)
  );

  // clock / memory device
  always #5 clock = ~clock;

  logic [DW-1:0] dev_mem [16];
  assign mem_rdata = dev_mem[mem_addr[5:2]];
  always @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++) begin
        if (mem_strobe[b]) dev_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // scoreboard
  typedef struct packed {
    logic g0; logic g1; logic lk;
    logic [CW-1:0] cnt; logic [1:0] st; logic [LW-1:0] lc;
  } stat_t;
  typedef struct packed {
    logic port; logic we; logic [SW-1:0] strobe;
    logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata;
  } gnt_t;
  stat_t stat_q[$];
  gnt_t  exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: loader burst length, tie-break preference, saturating count
  logic [DW-1:0] ref_mem [16];
  int  beats;       // locked loader grants in the current burst, 0 = not locked
  bit  yield_pend;  // next cycle is reserved for the CPU
  bit  prefer_ldr;  // who wins the next simultaneous request
  int  mcnt;
  bit  pend0, pend1;
  int  ldr_seq;

  task automatic model_reset();
    beats = 0; yield_pend = 0; prefer_ldr = 0; mcnt = 0; pend0 = 0; pend1 = 0;
  endtask

  task automatic cycle_begin();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic gen(input int p0, input int p1, input int pl);
    if (!pend0) begin
      if ($urandom_range(99) < p0) begin
        m0_if.req = 1'b1; m0_if.we = 1'($urandom_range(1));
        m0_if.strobe = SW'($urandom_range(15));
        m0_if.addr = AW'($urandom_range(15)) << 2; m0_if.wdata = $urandom;
      end else m0_if.req = 1'b0;
    end
    if (!pend1) begin
      if ($urandom_range(99) < p1) begin
        m1_if.req = 1'b1; m1_if.we = 1'($urandom_range(1));
        m1_if.strobe = SW'($urandom_range(15));
        m1_if.addr = AW'(32'h100 + 4 * ldr_seq); m1_if.wdata = $urandom;
        m1_lock = ($urandom_range(99) < pl);
        ldr_seq = (ldr_seq + 1) % 16;
      end else begin
        m1_if.req = 1'b0; m1_lock = 1'b0;
      end
    end
  endtask

  task automatic evaluate();
    bit r0, r1, g0, g1;
    stat_t s;
    gnt_t e;
    r0 = m0_if.req; r1 = m1_if.req; g0 = 0; g1 = 0;
    s.lk  = (beats > 0);
    s.cnt = CW'(mcnt);
    s.st  = yield_pend ? YIELD : ((beats > 0) ? LOCK : ARB);
    s.lc  = LW'(beats);
    if (yield_pend) begin
      g0 = r0; yield_pend = 0; prefer_ldr = 1;
    end else if (beats > 0) begin
      if (r1) begin
        g1 = 1; beats++;
        if (beats == ML) begin beats = 0; yield_pend = r0; end
        else if (!m1_lock) beats = 0;
      end else begin
        g0 = r0; beats = 0;
      end
    end else begin
      if (r0 && r1) begin
        if (prefer_ldr) g1 = 1; else g0 = 1;
      end else begin
        g0 = r0; g1 = r1;
      end
      if (g1 && m1_lock) beats = 1;
    end
    if (g0) prefer_ldr = 1;
    if (g1) prefer_ldr = 0;
    if (((r0 && !g0) || (r1 && !g1)) && mcnt < (1 << CW) - 1) mcnt++;
    if (g0 || g1) begin
      e.port   = g1;
      e.we     = g1 ? m1_if.we : m0_if.we;
      e.strobe = g1 ? m1_if.strobe : m0_if.strobe;
      e.addr   = g1 ? m1_if.addr : m0_if.addr;
      e.wdata  = g1 ? m1_if.wdata : m0_if.wdata;
      e.rdata  = ref_mem[e.addr[5:2]];
      exp_q.push_back(e);
      if (e.we) begin
        for (int b = 0; b < SW; b++) begin
          if (e.strobe[b]) ref_mem[e.addr[5:2]][8*b +: 8] = e.wdata[8*b +: 8];
        end
      end
    end
    s.g0 = g0; s.g1 = g1;
    stat_q.push_back(s);
    pend0 = r0 && !g0;
    pend1 = r1 && !g1;
  endtask

  task automatic step(input int p0, input int p1, input int pl);
    cycle_begin();
    gen(p0, p1, pl);
    evaluate();
  endtask

  // reset asserted mid-cycle with whatever requests are currently driven
  task automatic reset_cycle();
    stat_t s;
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    model_reset();
    s = '0;
    stat_q.push_back(s);
  endtask

  // monitor
  always @(negedge clock) begin
    stat_t s;
    gnt_t e;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("m0_gnt", 64'(m0_if.gnt), 64'(s.g0));
      chk("m1_gnt", 64'(m1_if.gnt), 64'(s.g1));
      chk("locked", 64'(locked), 64'(s.lk));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(s.cnt));
      chk("state", 64'(dbg_state), 64'(s.st));
      chk("lock_cnt", 64'(dbg_lock_cnt), 64'(s.lc));
      if (!s.g0 && !s.g1) begin
        chk("idle_mem_we", 64'(mem_we), 64'(0));
        chk("idle_mem_strobe", 64'(mem_strobe), 64'(0));
      end
    end
    if (m0_if.gnt || m1_if.gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("gnt_port", 64'(m1_if.gnt), 64'(e.port));
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_strobe", 64'(mem_strobe), 64'(e.strobe));
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        else chk("rdata", 64'(e.port ? m1_if.rdata : m0_if.rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] <= (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i] = (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end
    m0_if.req = 0; m0_if.we = 0; m0_if.strobe = '0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.strobe = '0; m1_if.addr = '0; m1_if.wdata = '0;
    m1_lock = 0; ldr_seq = 0;
    model_reset();
    repeat (2) @(posedge clock);

    // lone CPU read of 0x10
    reset_cycle();
    cycle_begin();
    m0_if.req = 1; m0_if.we = 0; m0_if.strobe = '0; m0_if.addr = 32'h10;
    m1_if.req = 0; m1_lock = 0;
    evaluate();
    step(0, 0, 0);

    // both ports contend, alternating grants
    reset_cycle();
    repeat (5) step(100, 100, 0);

    // continuous locked loader against a waiting CPU: forced yield, re-lock
    reset_cycle();
    ldr_seq = 0;
    repeat (12) step(100, 100, 100);

    // loader releases the lock on its 3rd beat
    reset_cycle();
    step(0, 100, 100);
    step(100, 100, 100);
    step(100, 100, 0);
    step(100, 0, 0);

    // reset in the middle of a burst
    reset_cycle();
    step(0, 100, 100);
    step(100, 100, 100);
    reset_cycle();
    step(0, 0, 0);
    step(0, 0, 0);

    // random traffic
    reset_cycle();
    repeat (1500) step($urandom_range(100), $urandom_range(100), $urandom_range(100));

    // conflict counter saturation
    reset_cycle();
    repeat ((1 << CW) + 5) step(100, 100, 0);
    step(0, 0, 0);
    @(negedge clock);
    #1;
    chk("conflict_sat", 64'(conflict_cnt), 64'(16'hFFFF));

    repeat (3) step(0, 0, 0);
    @(negedge clock);
    #1;
    chk("gnt_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("stat_queue_empty", 64'(stat_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
